sbox_lane_sched: RTL

- Sequencer and arbiter for one shared 32-bit S-box lane: four byte S-boxes, combinational or one-stage registered, outside this block.
- Serves two requesters:
  - round datapath: 128-bit SubBytes, issued as 4 words;
  - key expansion: 32-bit SubWord, issued as 1 word.
- Replaces four parallel 128-bit substitution copies with one time-shared lane.
- Sits between the round controller / key schedule and the lane instance.

---
 rtl/sbox_lane_sched.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sbox_lane_sched.sv
// sbox_lane_sched: sequencer/arbiter for one shared 32-bit S-box lane.
//
// Two requesters share the lane: the round datapath (128-bit state, issued as
// four 32-bit words, word 0 = bits [31:0] first) and the key schedule (one
// 32-bit word). Each requester may have at most one job outstanding; it is
// not eligible again until its previous result has been consumed.
//
// Parameter:
//   LANE_LAT  0: lane_out valid in the same cycle as lane_in
//             1: lane_out valid one cycle after lane_in
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   st_req_*  / st_rsp_*        state job request / response (128 bit)
//   key_req_* / key_rsp_*       key word request / response (32 bit)
//   lane_in, lane_issue         word to the lane and its qualifier
//   lane_out                    lane result
//   busy                        FSM not in IDLE
//
// Build option:
//   SBOX_SCHED_KEY_PREEMPT_EN   lets one key word slip in between two state
//                               words of a running state job.
module sbox_lane_sched #(
  parameter int LANE_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data,
  output logic [31:0]  lane_in,
  output logic         lane_issue,
  input  logic [31:0]  lane_out,
  output logic         busy
);

  if (LANE_LAT != 0 && LANE_LAT != 1) begin : g_bad_lat
    $error("sbox_lane_sched: LANE_LAT must be 0 or 1");
  end

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] KEY_RUN = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]   fsm_q, fsm_d;
  logic [1:0]   word_idx_q;
  logic [127:0] st_buf_q;
  logic [31:0]  key_buf_q;
  logic         rr_key_q;     // 1: key side wins the next tie
  logic         st_pend_q;    // final state word captured last edge
  logic         key_pend_q;   // key word captured last edge
  logic         st_elig, key_elig;
  logic         st_grant, key_grant;
  logic         key_preempt;
  logic         resume;       // current KEY_RUN interrupted a state job

  // The pend flags block re-grant during the one cycle between the final
  // capture and rsp_valid rising.
  assign st_elig  = !st_rsp_valid && !st_pend_q;
  assign key_elig = !key_rsp_valid && !key_pend_q;

  always_comb begin
    st_grant  = 1'b0;
    key_grant = 1'b0;
    if (rst_n && fsm_q == IDLE) begin
      if (st_req_valid && st_elig && key_req_valid && key_elig) begin
        st_grant  = !rr_key_q;
        key_grant = rr_key_q;
      end else begin
        st_grant  = st_req_valid && st_elig;
        key_grant = key_req_valid && key_elig;
      end
    end
  end

`ifdef SBOX_SCHED_KEY_PREEMPT_EN
  logic preempted_q, resume_q;

  // Only while issuing words 0..2, and only once per state job.
  assign key_preempt = rst_n && fsm_q == ST_RUN && !preempted_q &&
                       word_idx_q != 2'd3 && key_req_valid && key_elig;
  assign resume = resume_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      preempted_q <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      if (st_grant)         preempted_q <= 1'b0;
      else if (key_preempt) preempted_q <= 1'b1;
      if (key_preempt)          resume_q <= 1'b1;
      else if (fsm_q == KEY_RUN) resume_q <= 1'b0;
    end
  end
`else
  assign key_preempt = 1'b0;
  assign resume      = 1'b0;
`endif

  assign st_req_ready  = st_grant;
  assign key_req_ready = key_grant || key_preempt;
  assign busy          = fsm_q != IDLE;
  assign lane_issue    = fsm_q == ST_RUN || fsm_q == KEY_RUN;

  always_comb begin
    lane_in = 32'd0;
    if (fsm_q == ST_RUN)       lane_in = st_buf_q[{word_idx_q, 5'd0} +: 32];
    else if (fsm_q == KEY_RUN) lane_in = key_buf_q;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (st_grant)       fsm_d = ST_RUN;
        else if (key_grant) fsm_d = KEY_RUN;
      end
      ST_RUN: begin
        if (word_idx_q == 2'd3) fsm_d = (LANE_LAT == 1) ? DRAIN : IDLE;
        else if (key_preempt)   fsm_d = KEY_RUN;
      end
      KEY_RUN: begin
        if (resume) fsm_d = ST_RUN;
        else        fsm_d = (LANE_LAT == 1) ? DRAIN : IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Issue descriptor delayed by LANE_LAT cycles so capture lines up with
  // lane_out. Stage 0 is the live issue.
  logic       vld_pipe [LANE_LAT:0];
  logic       key_pipe [LANE_LAT:0];
  logic [1:0] idx_pipe [LANE_LAT:0];

  assign vld_pipe[0] = lane_issue;
  assign key_pipe[0] = fsm_q == KEY_RUN;
  assign idx_pipe[0] = word_idx_q;

  for (genvar s = 1; s <= LANE_LAT; s++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_pipe[s] <= 1'b0;
        key_pipe[s] <= 1'b0;
        idx_pipe[s] <= 2'd0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        key_pipe[s] <= key_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  logic       cap_v, cap_key;
  logic [1:0] cap_idx;
  assign cap_v   = vld_pipe[LANE_LAT];
  assign cap_key = key_pipe[LANE_LAT];
  assign cap_idx = idx_pipe[LANE_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q         <= IDLE;
      word_idx_q    <= 2'd0;
      st_buf_q      <= '0;
      key_buf_q     <= '0;
      rr_key_q      <= 1'b0;
      st_pend_q     <= 1'b0;
      key_pend_q    <= 1'b0;
      st_rsp_valid  <= 1'b0;
      st_rsp_data   <= '0;
      key_rsp_valid <= 1'b0;
      key_rsp_data  <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (st_grant) begin
        st_buf_q   <= st_req_data;
        word_idx_q <= 2'd0;
        rr_key_q   <= 1'b1;
      end else if (fsm_q == ST_RUN) begin
        word_idx_q <= word_idx_q + 2'd1;
      end
      if (key_req_ready) begin
        key_buf_q <= key_req_data;
        rr_key_q  <= 1'b0;
      end
      // Results land straight in the response registers: no new job for a
      // side can start until its previous response has been consumed.
      if (cap_v) begin
        if (cap_key) key_rsp_data <= lane_out;
        else         st_rsp_data[{cap_idx, 5'd0} +: 32] <= lane_out;
      end
      st_pend_q  <= cap_v && !cap_key && cap_idx == 2'd3;
      key_pend_q <= cap_v && cap_key;
      if (st_pend_q)         st_rsp_valid <= 1'b1;
      else if (st_rsp_ready) st_rsp_valid <= 1'b0;
      if (key_pend_q)         key_rsp_valid <= 1'b1;
      else if (key_rsp_ready) key_rsp_valid <= 1'b0;
    end
  end

endmodule
